// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Registers phase and halt on posedge; all strobes decode combinationally from them.
module cpu_sequencer #(
  parameter int unsigned OPC_W  = 3,
  parameter int unsigned NPHASE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase
);

  localparam logic [2:0] PhInstAddr  = 3'd0;
  localparam logic [2:0] PhInstFetch = 3'd1;
  localparam logic [2:0] PhInstLoad  = 3'd2;
  localparam logic [2:0] PhIdle      = 3'd3;
  localparam logic [2:0] PhOpAddr    = 3'd4;
  localparam logic [2:0] PhOpFetch   = 3'd5;
  localparam logic [2:0] PhAluOp     = 3'd6;
  localparam logic [2:0] PhStore     = 3'd7;
  localparam logic [2:0] PhLast      = 3'(NPHASE - 1);

  localparam logic [OPC_W-1:0] OpHlt = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpSkz = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpAnd = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpXor = OPC_W'(4);
  localparam logic [OPC_W-1:0] OpLda = OPC_W'(5);
  localparam logic [OPC_W-1:0] OpSto = OPC_W'(6);
  localparam logic [OPC_W-1:0] OpJmp = OPC_W'(7);

  logic [2:0] phase_q, phase_d;
  logic       halt_q, halt_d;

  logic is_hlt, is_skz, is_sto, is_jmp, alu_op, wait_st;

  assign is_hlt = (opcode == OpHlt);
  assign is_skz = (opcode == OpSkz);
  assign is_sto = (opcode == OpSto);
  assign is_jmp = (opcode == OpJmp);
  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                  (opcode == OpXor) || (opcode == OpLda);

  // Memory-facing phases stall until the memory handshakes.
  assign wait_st = !mem_ready &&
                   ((phase_q == PhInstFetch) || (phase_q == PhOpFetch) ||
                    ((phase_q == PhStore) && is_sto));

  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      if ((phase_q == PhOpAddr) && is_hlt) begin
        halt_d = 1'b1;
      end else if (!wait_st) begin
        phase_d = (phase_q == PhLast) ? PhInstAddr : phase_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PhInstAddr;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    if (!halt_q) begin
      unique case (phase_q)
        PhInstAddr: sel = 1'b1;
        PhInstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PhInstLoad, PhIdle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PhOpAddr:  inc_pc = 1'b1;
        PhOpFetch: rd = alu_op;
        PhAluOp: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PhStore: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign halt  = halt_q;
  assign phase = phase_q;

endmodule
